// File: rtl/dmem_responder.sv
// Data-memory responder for a small core: word RAM plus an MMIO block holding a
// 64-bit cycle counter, a byte-wide TX FIFO and a sticky halt register.
module dmem_responder #(
  parameter int WIDTH      = 32,
  parameter int DADDR      = 16,
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DADDR-1:0] dmem_addr,
  input  logic [WIDTH-1:0] dmem_wdata,
  input  logic [3:0]       dmem_wr_en,
  output logic [WIDTH-1:0] dmem_rdata,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             halt,
  output logic [7:0]       halt_code
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Address decode; byte offset bits [1:0] never take part.
  logic          ram_sel;
  logic          mmio_sel;
  logic [1:0]    mmio_off;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_bits;

  assign ram_sel          = ~dmem_addr[DADDR-1];
  assign mmio_sel         = &dmem_addr[DADDR-1:4];
  assign mmio_off         = dmem_addr[3:2];
  assign ram_idx          = dmem_addr[AW+1:2];
  assign unused_addr_bits = ^dmem_addr[1:0];

  logic tx_wr;
  logic halt_wr;
  assign tx_wr   = mmio_sel && (mmio_off == 2'd2) && dmem_wr_en[0];
  assign halt_wr = mmio_sel && (mmio_off == 2'd3) && dmem_wr_en[0];

  // RAM: byte-lane writes, no reset so contents survive reset pulses.
  logic [WIDTH-1:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_wr_en[i]) ram[ram_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
      end
    end
  end

  logic [63:0] cycle_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycle_cnt <= '0;
    else          cycle_cnt <= cycle_cnt + 64'd1;
  end

  // TX handshake: a byte leaves on a rising edge where tx_valid && tx_ready;
  // tx_data holds the head byte and cannot change until that pop happens.
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          fifo_full;
  logic          fifo_empty;
  logic          do_pop;
  logic          do_push;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign do_pop     = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push    = tx_wr && (!fifo_full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= dmem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
      if (tx_wr && !do_push) overflow <= 1'b1;
    end
  end

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halt      <= 1'b0;
      halt_code <= 8'h00;
    end else if (halt_wr && !halt) begin
      halt      <= 1'b1;
      halt_code <= dmem_wdata[7:0];
    end
  end

  logic [4:0]       count5;
  logic [WIDTH-1:0] tx_status;
  assign count5    = 5'(count);
  assign tx_status = {21'b0, overflow, fifo_empty, fifo_full, 3'b000, count5};

  always_comb begin
    dmem_rdata = '0;
    if (ram_sel) begin
      dmem_rdata = ram[ram_idx];
    end else if (mmio_sel) begin
      case (mmio_off)
        2'd0:    dmem_rdata = cycle_cnt[31:0];
        2'd1:    dmem_rdata = cycle_cnt[63:32];
        2'd2:    dmem_rdata = tx_status;
        default: dmem_rdata = {23'b0, halt, halt_code};
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: bus driver tasks, a TX byte scoreboard fed at push
// time and drained by a pop monitor, and one task per scenario.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wr_en;
  logic [31:0] dmem_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic [7:0]  halt_code;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wr_en (dmem_wr_en),
    .dmem_rdata (dmem_rdata),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .halt       (halt),
    .halt_code  (halt_code)
  );

  // Pop monitor: samples just before the rising edge on which a pop happens.
  always @(negedge clk) begin
    #4;
    if (reset_n && tx_valid && tx_ready) begin
      pops++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tx_pop_unexpected: got %02h, expected no byte", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          bad++;
          $display("FAIL tx_pop_data: got %02h, expected %02h", tx_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    dmem_wr_en = 4'h0;
    tx_ready   = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    dmem_addr  = a;
    dmem_wdata = d;
    dmem_wr_en = s;
    @(negedge clk);
    dmem_wr_en = 4'h0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    dmem_addr  = a;
    dmem_wr_en = 4'h0;
    #1;
    d = dmem_rdata;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && (tx_valid || exp_q.size() != 0); i++) @(negedge clk);
    #1;
    total++;
    if (tx_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: tx_valid=%b left=%0d, expected tx_valid=0 left=0",
               name, tx_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (tx_valid !== 1'b0 || halt !== 1'b0 || halt_code !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: tx_valid=%b halt=%b code=%02h, expected 0 0 00",
               tx_valid, halt, halt_code);
    end
    bus_read(16'hFFF8, r);
    total++;
    if (r !== 32'h0000_0200) begin
      bad++; $display("FAIL reset_status: got %08h, expected 00000200", r);
    end
    bus_read(16'hFFF0, r);
    total++;
    if (r !== 32'h0) begin
      bad++; $display("FAIL reset_cycle: got %08h, expected 00000000", r);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_ram();
    logic [31:0] r;
    bus_write(16'h0010, 32'hDEAD_BEEF, 4'hF);
    bus_write(16'h0010, 32'h0000_00AA, 4'h1);
    bus_read(16'h0010, r);
    total++;
    if (r !== 32'hDEAD_BEAA) begin
      bad++; $display("FAIL ram_lane_write: got %08h, expected deadbeaa", r);
    end
    bus_read(16'h0013, r);
    total++;
    if (r !== 32'hDEAD_BEAA) begin
      bad++; $display("FAIL ram_byte_offset: got %08h, expected deadbeaa", r);
    end
    bus_write(16'h1010, 32'h0011_2200, 4'h6);
    bus_read(16'h0010, r);
    total++;
    if (r !== 32'hDE11_22AA) begin
      bad++; $display("FAIL ram_alias: got %08h, expected de1122aa", r);
    end
    bus_write(16'h8010, 32'h5555_5555, 4'hF);
    bus_read(16'h0010, r);
    total++;
    if (r !== 32'hDE11_22AA) begin
      bad++; $display("FAIL unmapped_write: got %08h, expected de1122aa", r);
    end
    bus_read(16'h8010, r);
    total++;
    if (r !== 32'h0) begin
      bad++; $display("FAIL unmapped_read: got %08h, expected 00000000", r);
    end
  endtask

  task automatic test_cycle_counter();
    logic [31:0] r;
    apply_reset();
    repeat (10) @(posedge clk);
    bus_read(16'hFFF0, r);
    total++;
    if (r !== 32'd10) begin
      bad++; $display("FAIL cycle_lo_after_10: got %0d, expected 10", r);
    end
    @(negedge clk);
    force dut.cycle_cnt = 64'h0000_0005_FFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    @(posedge clk);
    #1;
    dmem_addr = 16'hFFF4;
    #1;
    total++;
    if (dmem_rdata !== 32'h6) begin
      bad++; $display("FAIL cycle_hi_carry: got %08h, expected 00000006", dmem_rdata);
    end
    dmem_addr = 16'hFFF0;
    #1;
    total++;
    if (dmem_rdata !== 32'h0) begin
      bad++; $display("FAIL cycle_lo_carry: got %08h, expected 00000000", dmem_rdata);
    end
    @(negedge clk);
    force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    @(posedge clk);
    #1;
    dmem_addr = 16'hFFF4;
    #1;
    total++;
    if (dmem_rdata !== 32'h0) begin
      bad++; $display("FAIL cycle_wrap64: got %08h, expected 00000000", dmem_rdata);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    logic [7:0]  head;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      bus_write(16'hFFF8, 32'h0000_0010 + i, 4'h1);
      if (exp_q.size() < 8) exp_q.push_back(8'(8'h10 + i));
    end
    bus_read(16'hFFF8, r);
    total++;
    if (r !== 32'h0000_0508) begin
      bad++; $display("FAIL overflow_status: got %08h, expected 00000508", r);
    end
    head = tx_data;
    repeat (3) @(negedge clk);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== head || head !== 8'h10) begin
      bad++;
      $display("FAIL tx_stall_stable: valid=%b data=%02h, expected 1 10", tx_valid, tx_data);
    end
    pops = 0;
    tx_ready = 1'b1;
    wait_drain("overflow");
    total++;
    if (pops != 8) begin
      bad++; $display("FAIL overflow_pop_count: got %0d, expected 8", pops);
    end
    tx_ready = 1'b0;
    bus_read(16'hFFF8, r);
    total++;
    if (r !== 32'h0000_0600) begin
      bad++; $display("FAIL overflow_sticky: got %08h, expected 00000600", r);
    end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] r;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      bus_write(16'hFFF8, 32'h0000_00A0 + i, 4'h1);
      exp_q.push_back(8'(8'hA0 + i));
    end
    @(negedge clk);
    tx_ready   = 1'b1;
    dmem_addr  = 16'hFFF8;
    dmem_wdata = 32'h0000_00C0;
    dmem_wr_en = 4'h1;
    exp_q.push_back(8'hC0);
    @(negedge clk);
    tx_ready   = 1'b0;
    dmem_wr_en = 4'h0;
    bus_read(16'hFFF8, r);
    total++;
    if (r !== 32'h0000_0108) begin
      bad++; $display("FAIL full_push_pop_status: got %08h, expected 00000108", r);
    end
    tx_ready = 1'b1;
    wait_drain("full_push_pop");
    tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    apply_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      bus_write(16'hFFF8, {24'($urandom_range(0, 65535)), b}, 4'($urandom_range(1, 15)) | 4'h1);
      exp_q.push_back(b);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    bus_write(16'hFFF8, 32'h0000_00FF, 4'hE);
    wait_drain("stream");
    tx_ready = 1'b0;
  endtask

  task automatic test_halt();
    logic [31:0] r;
    apply_reset();
    bus_write(16'hFFFC, 32'h0000_0033, 4'hE);
    #1;
    total++;
    if (halt !== 1'b0) begin
      bad++; $display("FAIL halt_no_lane0: halt=%b, expected 0", halt);
    end
    bus_write(16'hFFFC, 32'h0000_002A, 4'h1);
    bus_write(16'hFFFC, 32'h0000_0055, 4'hF);
    #1;
    total++;
    if (halt !== 1'b1 || halt_code !== 8'h2A) begin
      bad++; $display("FAIL halt_sticky: halt=%b code=%02h, expected 1 2a", halt, halt_code);
    end
    bus_read(16'hFFFC, r);
    total++;
    if (r !== 32'h0000_012A) begin
      bad++; $display("FAIL halt_read: got %08h, expected 0000012a", r);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [31:0] r;
    apply_reset();
    bus_write(16'h0010, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 3; i++) begin
      bus_write(16'hFFF8, 32'h0000_0070 + i, 4'h1);
      exp_q.push_back(8'(8'h70 + i));
    end
    bus_write(16'hFFFC, 32'h0000_0077, 4'h1);
    #1;
    total++;
    if (tx_valid !== 1'b1 || halt !== 1'b1) begin
      bad++; $display("FAIL pre_reset_state: tx_valid=%b halt=%b, expected 1 1", tx_valid, halt);
    end
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    total++;
    if (tx_valid !== 1'b0 || halt !== 1'b0) begin
      bad++; $display("FAIL async_reset: tx_valid=%b halt=%b, expected 0 0", tx_valid, halt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(16'hFFF0, r);
    total++;
    if (r !== 32'd1) begin
      bad++; $display("FAIL cycle_after_reset: got %0d, expected 1", r);
    end
    bus_read(16'h0010, r);
    total++;
    if (r !== 32'h1234_5678) begin
      bad++; $display("FAIL ram_retained: got %08h, expected 12345678", r);
    end
    bus_read(16'hFFF8, r);
    total++;
    if (r !== 32'h0000_0200) begin
      bad++; $display("FAIL fifo_discarded: got %08h, expected 00000200", r);
    end
  endtask

  initial begin
    reset_n    = 1'b1;
    dmem_addr  = 16'h0;
    dmem_wdata = 32'h0;
    dmem_wr_en = 4'h0;
    tx_ready   = 1'b0;
    test_reset();
    test_ram();
    test_cycle_counter();
    test_overflow();
    test_push_pop_full();
    test_back_to_back();
    test_halt();
    test_reset_mid_stream();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
